register_file_mp: RTL and testbench

Parametrised successor to the core's 2R/1W integer register file. It provides NRD combinational read ports and two write ports (WB0 has priority over WB1), with optional write-to-read bypass and a hardwired-zero x0. It also holds a per-register busy scoreboard for pipeline hazard detection. It sits in decode (reads, issue) and write-back (writes, scoreboard clear).

---
 rtl/register_file_mp.sv | 147 ++++++++++++++
 tb/tb_register_file_mp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
//   Multi-ported integer register file with NRD combinational read ports and
//   two write ports (WB0 wins over WB1 on an address collision). It offers an
//   optional write-to-read bypass and an optional hardwired-zero register 0.
//   A per-register busy scoreboard supports hazard detection in decode.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (state clears while rst = 0)
//   ra        NRD packed read addresses, port k at [k*AW +: AW]
//   rd        NRD packed read data, port k at [k*XLEN +: XLEN]
//   rbusy     stored busy bit of each read address
//   we0/wa0/wd0  write port 0 (priority)
//   we1/wa1/wd1  write port 1
//   iss_en    mark iss_rd busy
//   iss_rd    destination register being issued
//   flush     synchronous clear of every busy bit
//   busy_vec  full scoreboard, bit i = register i busy
// -----------------------------------------------------------------------------
module register_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            we1_eff_s;

    // Port 1 is dropped when port 0 writes the same address in the same cycle
    always_comb begin
        if (we0 && (wa0 == wa1)) begin
            we1_eff_s = 1'b0;
        end else begin
            we1_eff_s = we1;
        end
    end

    // Next-state register contents from the two write ports
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if ((ZERO_REG != 0) && (i == 0)) begin
                regs_d[i] = '0;
            end else if (we0 && (wa0 == AW'(i))) begin
                regs_d[i] = wd0;
            end else if (we1_eff_s && (wa1 == AW'(i))) begin
                regs_d[i] = wd1;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Next-state scoreboard: flush, then issue-set, then write-back clear
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if ((ZERO_REG != 0) && (i == 0)) begin
                busy_d[i] = 1'b0;
            end else if (flush) begin
                // The issue arriving with the flush is the first post-flush issue
                busy_d[i] = iss_en && (iss_rd == AW'(i));
            end else if (iss_en && (iss_rd == AW'(i))) begin
                // Set beats clear: a reused destination retiring now stays busy
                busy_d[i] = 1'b1;
            end else if ((we0 && (wa0 == AW'(i))) || (we1 && (wa1 == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Register array and scoreboard state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Combinational read ports with optional same-cycle forwarding
    always_comb begin
        logic [AW-1:0] ra_k;
        rd    = '0;
        rbusy = '0;
        ra_k  = '0;
        for (int k = 0; k < NRD; k++) begin
            ra_k = ra[k*AW +: AW];
            if (!rst) begin
                rd[k*XLEN +: XLEN] = '0;
                rbusy[k]           = 1'b0;
            end else if ((ZERO_REG != 0) && (ra_k == '0)) begin
                rd[k*XLEN +: XLEN] = '0;
                rbusy[k]           = 1'b0;
            end else begin
                if ((BYPASS != 0) && we0 && (wa0 == ra_k)) begin
                    rd[k*XLEN +: XLEN] = wd0;
                end else if ((BYPASS != 0) && we1 && (wa1 == ra_k)) begin
                    rd[k*XLEN +: XLEN] = wd1;
                end else begin
                    rd[k*XLEN +: XLEN] = regs_q[ra_k];
                end
                // Busy is deliberately not forwarded: a clear is seen next cycle
                rbusy[k] = busy_q[ra_k];
            end
        end
    end

    // Scoreboard view forced to zero while reset is held
    always_comb begin
        if (!rst) begin
            busy_vec = '0;
        end else begin
            busy_vec = busy_q;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    logic        clk;
    logic        rst;
    logic [19:0] ra4;
    logic        we0, we1, iss_en, flush;
    logic [4:0]  wa0, wa1, iss_rd;
    logic [31:0] wd0, wd1;

    logic [127:0] rd_a;
    logic [3:0]   rbusy_a;
    logic [31:0]  bv_a;
    logic [63:0]  rd_b;
    logic [1:0]   rbusy_b;
    logic [31:0]  bv_b;

    // Bypassing four-port instance
    register_file_mp #(.XLEN(32), .NREG(32), .NRD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .ra(ra4), .rd(rd_a), .rbusy(rbusy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_vec(bv_a));

    // Non-bypassing two-port instance on the same write/issue stream
    register_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst), .ra(ra4[9:0]), .rd(rd_b), .rbusy(rbusy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_vec(bv_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] rd4;
        logic [3:0]   rb4;
        logic [63:0]  rd2;
        logic [1:0]   rb2;
        logic [31:0]  bv;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: architectural contents and busy set
    logic [31:0] mem [32];
    logic [31:0] m_busy;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we0 && wa0 == a) return wd0;
        if (byp && we1 && wa1 == a) return wd1;
        return mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        m_busy = 32'd0;
    endtask

    task automatic model_update();
        if (we0 && wa0 != 5'd0) mem[wa0] = wd0;
        if (we1 && !(we0 && wa0 == wa1) && wa1 != 5'd0) mem[wa1] = wd1;
        if (flush) begin
            m_busy = 32'd0;
            if (iss_en) m_busy[iss_rd] = 1'b1;
        end else begin
            if (we0) m_busy[wa0] = 1'b0;
            if (we1) m_busy[wa1] = 1'b0;
            if (iss_en) m_busy[iss_rd] = 1'b1;
        end
        m_busy[0] = 1'b0;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0; flush = 1'b0;
        wa0 = 5'd0; wa1 = 5'd0; iss_rd = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
        ra4 = 20'd0;
    endtask

    // Issue the current inputs for one cycle: predict, push, then advance the model
    task automatic cycle(input string nm);
        exp_t e;
        logic [4:0] a;
        if (!rst) model_clear();
        for (int k = 0; k < 4; k++) begin
            a = ra4[k*5 +: 5];
            e.rd4[k*32 +: 32] = rst ? m_read(a, 1'b1) : 32'd0;
            e.rb4[k] = rst && (a != 5'd0) && m_busy[a];
        end
        for (int k = 0; k < 2; k++) begin
            a = ra4[k*5 +: 5];
            e.rd2[k*32 +: 32] = rst ? m_read(a, 1'b0) : 32'd0;
            e.rb2[k] = rst && (a != 5'd0) && m_busy[a];
        end
        e.bv = rst ? m_busy : 32'd0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        if (rst) model_update();
        #2;
    endtask

    // Monitor: the read outputs settle mid-cycle and are compared on the falling edge
    exp_t  mon_e;
    string mon_n;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            chk({mon_n, ".rd_a"},    rd_a,    mon_e.rd4);
            chk({mon_n, ".rbusy_a"}, {124'd0, rbusy_a}, {124'd0, mon_e.rb4});
            chk({mon_n, ".bv_a"},    {96'd0, bv_a},     {96'd0, mon_e.bv});
            chk({mon_n, ".rd_b"},    {64'd0, rd_b},     {64'd0, mon_e.rd2});
            chk({mon_n, ".rbusy_b"}, {126'd0, rbusy_b}, {126'd0, mon_e.rb2});
            chk({mon_n, ".bv_b"},    {96'd0, bv_b},     {96'd0, mon_e.bv});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        rst = 1'b0;
        idle();
        @(posedge clk);
        #2;
        cycle("reset");

        // Reset mid-operation
        rst = 1'b1;
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra4[4:0] = 5'd5;
        cycle("pre_x5");
        idle(); ra4[4:0] = 5'd5; ra4[9:5] = 5'd5;
        cycle("read_x5");
        rst = 1'b0; we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h1111_2222; iss_en = 1'b1; iss_rd = 5'd5;
        cycle("rst_mid");
        rst = 1'b1; idle(); ra4[4:0] = 5'd5; ra4[9:5] = 5'd6;
        cycle("post_rst");

        // Bypass vs stored-only read
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678; ra4 = {5'd7, 5'd7, 5'd7, 5'd7};
        cycle("bypass");
        idle(); ra4 = {5'd0, 5'd7, 5'd7, 5'd7};
        cycle("bypass_next");

        // Same-address write conflict
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd9; wa1 = 5'd9; wd0 = 32'hA; wd1 = 32'hB;
        ra4 = {5'd9, 5'd9, 5'd9, 5'd9};
        cycle("conflict");
        idle(); ra4 = {5'd9, 5'd9, 5'd9, 5'd9};
        cycle("conflict_next");

        // Hardwired zero
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; iss_en = 1'b1; iss_rd = 5'd0;
        cycle("x0");
        idle();
        cycle("x0_next");

        // Scoreboard set/clear race
        iss_en = 1'b1; iss_rd = 5'd4;
        cycle("sb_iss4");
        idle(); we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44; iss_en = 1'b1; iss_rd = 5'd4; ra4[4:0] = 5'd4;
        cycle("sb_race");
        idle(); we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h45; ra4[4:0] = 5'd4;
        cycle("sb_clear");
        idle(); ra4[4:0] = 5'd4;
        cycle("sb_after");

        // Flush with a simultaneous issue
        iss_en = 1'b1; iss_rd = 5'd3;  cycle("iss3");
        iss_rd = 5'd6;                 cycle("iss6");
        iss_rd = 5'd10;                cycle("iss10");
        idle(); flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd12; ra4 = {5'd12, 5'd10, 5'd6, 5'd3};
        cycle("flush");
        idle(); ra4 = {5'd12, 5'd10, 5'd6, 5'd3};
        cycle("flush_next");

        // Randomised traffic on all four ports
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 63) != 0);
            we0    = $urandom_range(0, 1);
            we1    = $urandom_range(0, 1);
            wa0    = 5'($urandom_range(0, 31));
            wa1    = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            wd0    = $urandom;
            wd1    = $urandom;
            iss_en = $urandom_range(0, 1);
            iss_rd = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom_range(0, 31));
            flush  = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0:       ra4[k*5 +: 5] = wa0;
                    1:       ra4[k*5 +: 5] = wa1;
                    default: ra4[k*5 +: 5] = 5'($urandom_range(0, 31));
                endcase
            end
            cycle("rand");
        end
        rst = 1'b1;
        idle();
        cycle("final");

        @(negedge clk);
        #1;
        chk("drain", {96'd0, 32'(exp_q.size())}, 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
